// File: rtl/stream_normalizer.sv
// stream_normalizer
//   Repacks an AXI4-Stream whose beats carry any LSB-aligned contiguous byte
//   count (including zero) into a normalized stream: every non-last beat is
//   full, and the last beat is LSB-contiguous (possibly empty). Bytes that do
//   not fill a beat are parked in a residue register until more arrive or the
//   stream ends. A final input beat that overflows the output beat costs one
//   extra FLUSH cycle to emit the leftover residue.
//
// Ports
//   clk, rst_n                      clock; asynchronous active-low reset
//   input_data_tdata/tkeep/tlast    input payload, contiguous keep, end of stream
//   input_data_tvalid/tready        input handshake
//   output_data_tdata/tkeep/tlast   packed payload (registered)
//   output_data_tvalid/tready       output handshake (tvalid registered)
module stream_normalizer #(
  parameter int DATA_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*DATA_BYTES-1:0] input_data_tdata,
  input  logic [DATA_BYTES-1:0]   input_data_tkeep,
  input  logic                    input_data_tlast,
  input  logic                    input_data_tvalid,
  output logic                    input_data_tready,
  output logic [8*DATA_BYTES-1:0] output_data_tdata,
  output logic [DATA_BYTES-1:0]   output_data_tkeep,
  output logic                    output_data_tlast,
  output logic                    output_data_tvalid,
  input  logic                    output_data_tready
);

  localparam int CW = $clog2(DATA_BYTES);
  localparam int TW = CW + 2;
  localparam int DW = 8 * DATA_BYTES;
  localparam int RW = 8 * (DATA_BYTES - 1);
  localparam logic [TW-1:0] DB_T = TW'(DATA_BYTES);

  typedef enum logic {ACCEPT, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       r_q, r_d;
  logic [RW-1:0]       res_q, res_d;
  logic [DW-1:0]       tdata_p1, tdata_d;
  logic [DATA_BYTES-1:0] keep_p1, keep_d;
  logic                last_p1, last_d;
  logic                vld_p1, vld_d;

  logic [TW-1:0]       k, t;
  logic [DW-1:0]       in_masked;
  logic [DW+RW-1:0]    cat;
  logic [DW-1:0]       cat_lo;
  logic [RW-1:0]       cat_hi;
  logic                out_free, accept;

  function automatic logic [DW-1:0] keep_bytes(input logic [DATA_BYTES-1:0] keep);
    logic [DW-1:0] m;
    for (int i = 0; i < DATA_BYTES; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  function automatic logic [DATA_BYTES-1:0] keep_mask(input logic [TW-1:0] n);
    logic [DATA_BYTES-1:0] m;
    for (int i = 0; i < DATA_BYTES; i++) m[i] = (TW'(i) < n);
    return m;
  endfunction

  // Input stage: merge the incoming bytes above the residue. Bytes outside
  // tkeep are zeroed so partial beats and the residue never carry garbage.
  assign k         = TW'($countones(input_data_tkeep));
  assign t         = {2'b00, r_q} + k;
  assign in_masked = input_data_tdata & keep_bytes(input_data_tkeep);
  assign cat       = ({{RW{1'b0}}, in_masked} << {r_q, 3'b000}) | {{DW{1'b0}}, res_q};
  assign cat_lo    = cat[DW-1:0];
  assign cat_hi    = cat[DW+RW-1:DW];

  assign out_free          = !vld_p1 || output_data_tready;
  assign input_data_tready = rst_n && (state_q == ACCEPT) && out_free;
  assign accept            = input_data_tvalid && input_data_tready;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    res_d   = res_q;
    tdata_d = tdata_p1;
    keep_d  = keep_p1;
    last_d  = last_p1;
    vld_d   = vld_p1 && !output_data_tready;
    case (state_q)
      ACCEPT: begin
        if (accept) begin
          // t - DATA_BYTES equals the low CW bits of t whenever t >= DATA_BYTES
          r_d = t[CW-1:0];
          if (!input_data_tlast) begin
            if (t < DB_T) begin
              res_d = cat_lo[RW-1:0];
            end else begin
              tdata_d = cat_lo;
              keep_d  = '1;
              last_d  = 1'b0;
              vld_d   = 1'b1;
              res_d   = cat_hi;
            end
          end else if (t <= DB_T) begin
            tdata_d = cat_lo;
            keep_d  = keep_mask(t);
            last_d  = 1'b1;
            vld_d   = 1'b1;
            r_d     = '0;
            res_d   = '0;
          end else begin
            tdata_d = cat_lo;
            keep_d  = '1;
            last_d  = 1'b0;
            vld_d   = 1'b1;
            res_d   = cat_hi;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          tdata_d = {8'h00, res_q};
          keep_d  = keep_mask({2'b00, r_q});
          last_d  = 1'b1;
          vld_d   = 1'b1;
          r_d     = '0;
          res_d   = '0;
          state_d = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // Output stage: one registered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCEPT;
      r_q      <= '0;
      res_q    <= '0;
      tdata_p1 <= '0;
      keep_p1  <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      res_q    <= res_d;
      tdata_p1 <= tdata_d;
      keep_p1  <= keep_d;
      last_p1  <= last_d;
      vld_p1   <= vld_d;
    end
  end

  assign output_data_tdata  = tdata_p1;
  assign output_data_tkeep  = keep_p1;
  assign output_data_tlast  = last_p1;
  assign output_data_tvalid = vld_p1;

  logic [DATA_BYTES-1:0] keep_inc;
  assign keep_inc = input_data_tkeep + DATA_BYTES'(1);

  a_keep_contig: assert property (@(posedge clk) disable iff (!rst_n)
    input_data_tvalid |-> $onehot0(keep_inc));
  a_full_nonlast: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p1 && !last_p1) |-> &keep_p1);
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p1 && !output_data_tready) |=>
      (vld_p1 && $stable(tdata_p1) && $stable(keep_p1) && $stable(last_p1)));

endmodule

// File: tb/tb_stream_normalizer.sv
module tb_stream_normalizer;

  localparam int DB = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [511:0]  in_tdata;
  logic [63:0]   in_tkeep;
  logic          in_tlast, in_tvalid, in_tready;
  logic [511:0]  out_tdata;
  logic [63:0]   out_tkeep;
  logic          out_tlast, out_tvalid, out_tready;

  stream_normalizer #(.DATA_BYTES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .input_data_tdata(in_tdata), .input_data_tkeep(in_tkeep),
    .input_data_tlast(in_tlast), .input_data_tvalid(in_tvalid),
    .input_data_tready(in_tready),
    .output_data_tdata(out_tdata), .output_data_tkeep(out_tkeep),
    .output_data_tlast(out_tlast), .output_data_tvalid(out_tvalid),
    .output_data_tready(out_tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int vld; int k; int last; int b0; int ordy;
    int e_rdy; int e_vld; int e_n; int e_last; int e_b0;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  logic [7:0] byte_q[$];
  int         len_q[$];
  int         cur_rem;
  bit         need_len;
  bit         acc;
  int         beat_no;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(int b0, int n, logic [7:0] fill);
    logic [511:0] p;
    for (int j = 0; j < DB; j++) p[8*j +: 8] = (j < n) ? 8'(b0 + j) : fill;
    return p;
  endfunction

  function automatic logic [63:0] kmask(int n);
    logic [63:0] m;
    for (int j = 0; j < DB; j++) m[j] = (j < n);
    return m;
  endfunction

  // Scoreboard for one output beat that handshakes at the coming edge.
  task automatic mon();
    bit ok;
    int n;
    logic [7:0] eb;
    if (out_tvalid && out_tready) begin
      ok = 1'b1;
      beat_no++;
      if (need_len) begin
        if (len_q.size() == 0) begin ok = 1'b0; cur_rem = 0; end
        else cur_rem = len_q.pop_front();
        need_len = 1'b0;
      end
      n = $countones(out_tkeep);
      if (out_tkeep !== kmask(n)) ok = 1'b0;
      if (!out_tlast) begin
        if (n != DB || cur_rem < DB) ok = 1'b0;
      end else if (n != cur_rem) ok = 1'b0;
      for (int j = 0; j < DB; j++) begin
        if (j < n) begin
          if (byte_q.size() == 0) ok = 1'b0;
          else begin
            eb = byte_q.pop_front();
            if (out_tdata[8*j +: 8] !== eb) ok = 1'b0;
          end
        end else if (out_tdata[8*j +: 8] !== 8'h00) ok = 1'b0;
      end
      cur_rem = cur_rem - n;
      if (out_tlast) need_len = 1'b1;
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rand_beat%0d actual keep=%h last=%b required bytes_left=%0d", beat_no, out_tkeep, out_tlast, cur_rem + n);
      end
    end
  endtask

  task automatic rcycle();
    @(negedge clk);
    mon();
    acc = in_tvalid && in_tready;
    @(posedge clk);
    #1;
    out_tready = ($urandom_range(0, 9) >= 3);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, cyc, total;
    int ks[3];
    logic [511:0] d;
    logic [7:0] bv;

    // vld k last b0 ordy | e_rdy e_vld e_n e_last e_b0
    tbl.push_back('{1, 32, 0,   0, 1, 1, 0,  0, 0,   0});
    tbl.push_back('{1, 32, 0,  32, 1, 1, 1, 64, 0,   0});
    tbl.push_back('{1, 64, 1,  64, 1, 1, 1, 64, 1,  64});
    tbl.push_back('{1, 48, 0, 100, 1, 1, 0,  0, 0,   0});
    tbl.push_back('{1, 48, 1, 148, 1, 1, 1, 64, 0, 100});
    tbl.push_back('{1,  8, 1,   0, 1, 0, 1, 32, 1, 164});
    tbl.push_back('{1,  8, 1,   0, 1, 1, 1,  8, 1,   0});
    tbl.push_back('{1,  0, 1,   0, 1, 1, 1,  0, 1,   0});
    tbl.push_back('{1,  0, 0,   0, 1, 1, 0,  0, 0,   0});
    tbl.push_back('{1, 64, 0,   0, 1, 1, 1, 64, 0,   0});
    tbl.push_back('{1,  0, 0,   0, 1, 1, 0,  0, 0,   0});
    tbl.push_back('{1, 64, 0,  64, 1, 1, 1, 64, 0,  64});
    tbl.push_back('{1,  0, 1,   0, 1, 1, 1,  0, 1,   0});
    tbl.push_back('{1, 40, 0,   0, 1, 1, 0,  0, 0,   0});
    tbl.push_back('{1, 40, 1,  40, 1, 1, 1, 64, 0,   0});
    tbl.push_back('{0,  0, 0,   0, 0, 0, 1, 64, 0,   0});
    tbl.push_back('{0,  0, 0,   0, 1, 0, 1, 16, 1,  64});
    tbl.push_back('{1, 64, 0,   0, 0, 0, 1, 16, 1,  64});
    tbl.push_back('{1, 64, 0,   0, 1, 1, 1, 64, 0,   0});
    tbl.push_back('{0,  0, 0,   0, 1, 1, 0,  0, 0,   0});

    rst_n = 1'b0;
    in_tvalid = 1'b1; in_tkeep = kmask(8); in_tdata = pat(1, 8, 8'h00);
    in_tlast = 1'b1; out_tready = 1'b1;
    #12;
    check("rst_tready", 512'(in_tready), 512'(1'b0));
    check("rst_tvalid", 512'(out_tvalid), 512'(1'b0));
    check("rst_tlast", 512'(out_tlast), 512'(1'b0));
    check("rst_tkeep", 512'(out_tkeep), 512'(0));
    check("rst_tdata", out_tdata, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      in_tvalid  = (v.vld != 0);
      in_tkeep   = kmask(v.k);
      in_tdata   = pat(v.b0, v.k, 8'hEE);
      in_tlast   = (v.last != 0);
      out_tready = (v.ordy != 0);
      #1;
      check($sformatf("row%0d_in_tready", i), 512'(in_tready), 512'(v.e_rdy != 0));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_tvalid", i), 512'(out_tvalid), 512'(v.e_vld != 0));
      if (v.e_vld != 0) begin
        check($sformatf("row%0d_tkeep", i), 512'(out_tkeep), 512'(kmask(v.e_n)));
        check($sformatf("row%0d_tlast", i), 512'(out_tlast), 512'(v.e_last != 0));
        check($sformatf("row%0d_tdata", i), out_tdata, pat(v.e_b0, v.e_n, 8'h00));
      end
    end

    // Build r=40 with a stalled full output beat, then reset asynchronously.
    in_tvalid = 1'b1; in_tkeep = kmask(40); in_tdata = pat(0, 40, 8'hEE);
    in_tlast = 1'b0; out_tready = 1'b1;
    @(posedge clk); #1;
    in_tkeep = kmask(64); in_tdata = pat(40, 64, 8'hEE); out_tready = 1'b0;
    @(posedge clk); #1;
    check("prerst_tvalid", 512'(out_tvalid), 512'(1'b1));
    in_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    in_tvalid = 1'b1;
    #1;
    check("arst_tvalid", 512'(out_tvalid), 512'(1'b0));
    check("arst_tkeep", 512'(out_tkeep), 512'(0));
    check("arst_tlast", 512'(out_tlast), 512'(1'b0));
    check("arst_tdata", out_tdata, 512'(0));
    check("arst_tready", 512'(in_tready), 512'(1'b0));
    in_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_tvalid = 1'b1; in_tkeep = kmask(8); in_tdata = pat(200, 8, 8'hEE);
    in_tlast = 1'b1; out_tready = 1'b1;
    #1;
    check("post_rst_tready", 512'(in_tready), 512'(1'b1));
    @(posedge clk); #1;
    check("post_rst_tvalid", 512'(out_tvalid), 512'(1'b1));
    check("post_rst_tkeep", 512'(out_tkeep), 512'(64'hFF));
    check("post_rst_tlast", 512'(out_tlast), 512'(1'b1));
    check("post_rst_tdata", out_tdata, pat(200, 8, 8'h00));
    in_tvalid = 1'b0;
    @(posedge clk); #1;

    // Random streams against a byte-queue scoreboard.
    need_len = 1'b1; cur_rem = 0; beat_no = 0;
    for (int s = 0; s < 1000; s++) begin
      nb = $urandom_range(1, 3);
      total = 0;
      for (int b = 0; b < nb; b++) begin
        ks[b] = $urandom_range(0, 64);
        total += ks[b];
      end
      len_q.push_back(total);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 4) == 0) begin
          in_tvalid = 1'b0;
          rcycle();
        end
        for (int j = 0; j < DB; j++) begin
          if (j < ks[b]) begin
            bv = 8'($urandom_range(0, 255));
            byte_q.push_back(bv);
            d[8*j +: 8] = bv;
          end else d[8*j +: 8] = 8'hA5;
        end
        in_tdata = d; in_tkeep = kmask(ks[b]);
        in_tlast = (b == nb - 1); in_tvalid = 1'b1;
        cyc = 0;
        do begin
          rcycle();
          cyc++;
        end while (!acc && cyc < 100);
        if (!acc) begin
          checks++;
          failures++;
          $display("FAIL rand_accept stream%0d beat%0d actual=not_accepted required=accepted", s, b);
        end
        in_tvalid = 1'b0;
      end
    end
    in_tvalid = 1'b0;
    repeat (40) rcycle();
    check("rand_bytes_left", 512'(byte_q.size()), 512'(0));
    check("rand_streams_left", 512'(len_q.size()), 512'(0));
    check("rand_stream_closed", 512'(need_len), 512'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
